exc_arbiter: RTL and testbench
==============================

// Module: exc_arbiter
// PURPOSE
//  Commit-point exception/interrupt arbiter between the MEM stage and cop0.
//  Prioritises the MEM-stage instruction's exception flags against pending
//  interrupts, and drives cop0's exception-capture ports (exception, exc_code, exc_pc,
//  BD, BadVAddr, ERET). Issues a pipeline flush and a redirect PC to IF,
//  held under a valid/ready handshake. Also synchronises the external interrupt lines.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380  general exception entry PC
//  SYNC_STAGES  2              flops on hw_int_async path (>=2)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous, active-high reset
//  mem_valid       in   1   MEM stage holds a real instruction this cycle
//  mem_pc          in   32  PC of MEM instruction
//  mem_is_bd       in   1   MEM instruction sits in a branch delay slot
//  mem_adel_if     in   1   fetch address error (BadVAddr=mem_pc)
//  mem_ri          in   1   reserved instruction
//  mem_ov          in   1   arithmetic overflow
//  mem_syscall     in   1   SYSCALL
//  mem_break       in   1   BREAK
//  mem_adel_ld     in   1   load address error (BadVAddr=mem_badaddr)
//  mem_ades        in   1   store address error (BadVAddr=mem_badaddr)
//  mem_eret        in   1   ERET
//  mem_badaddr     in   32  data address of MEM load/store
//  hw_int_async    in   6   asynchronous external interrupt lines
//  cp0_is_ie       in   1   Status.IE
//  cp0_is_exl      in   1   Status.EXL
//  cp0_int_mask    in   8   Status.IM[7:0]
//  cp0_soft_int    in   2   Cause.IP[1:0]
//  cp0_epc         in   32  current EPC
//  redirect_ready  in   1   IF accepts redirect
//  hw_int_sync     out  6   synchronised lines -> cop0 hardware_int
//  exc_valid       out  1   -> cop0 is_exception (1-cycle pulse)
//  exc_code        out  5   -> cop0 exc_code
//  exc_pc          out  32  -> cop0 exc_pc (EPC value)
//  exc_bd          out  1   -> cop0 is_bd
//  exc_we_badvaddr out  1   -> cop0 we_badvaddr
//  exc_badvaddr    out  32  -> cop0 badvaddr
//  exc_eret        out  1   -> cop0 is_excep_return (1-cycle pulse)
//  flush           out  1   kill IF..MEM, block MEM side effects
//  redirect_valid  out  1   redirect_pc valid
//  redirect_pc     out  32  new fetch PC
// BEHAVIOUR
//  Reset: state=IDLE; sync flops, flush, redirect_valid, redirect_pc = 0.
//  exc_* outputs are combinational and therefore 0 under reset (state forced IDLE, all gated off).
//  hw_int_sync = last of SYNC_STAGES flop chain (latency SYNC_STAGES cycles).
//  int_req = cp0_is_ie & ~cp0_is_exl & |({hw_int_sync,cp0_soft_int} & cp0_int_mask).
//  take = state==IDLE & mem_valid. Combinational from MEM inputs, cop0 captures same edge.
//  Priority when take (highest first): int_req 5'h00 > mem_adel_if 5'h04 > mem_ri 5'h0A
//   > mem_ov 5'h0C > mem_syscall 5'h08 > mem_break 5'h09 > mem_adel_ld 5'h04
//   > mem_ades 5'h05 > mem_eret. Exactly one winner.
//  Exception winner: exc_valid=1, exc_bd=mem_is_bd, exc_pc = mem_is_bd ? mem_pc-4 : mem_pc
//   (mod 2^32). exc_we_badvaddr=1 only for AdEL/AdES; exc_badvaddr from the AdEL/AdES source listed above.
//  ERET winner (no exception): exc_eret=1, exc_valid=0.
//  FSM IDLE->REDIR on any winner: flush<=1, redirect_valid<=1,
//   redirect_pc<= EXC_VECTOR (exception) or cp0_epc sampled that cycle (ERET).
//  REDIR: flush, redirect_valid, redirect_pc held stable; MEM flags ignored
//   (no exc_valid/exc_eret). On redirect_ready: ->IDLE, flush<=0, valid<=0.
//  redirect_ready high on the REDIR entry cycle itself: still one REDIR cycle (min 1-cycle flush).
//  mem_valid=0: no winner, interrupts stay pending until a valid instruction.
//  rst mid-REDIR: ->IDLE next edge, flush/redirect_valid drop, no pulse emitted.
// TESTING
//  1 mem_valid,mem_ov,mem_pc=0x80000010 -> exc_valid,code 0x0C,exc_pc 0x80000010; redirect 0xBFC00380.
//  2 mem_is_bd=1,mem_ades,mem_pc=0x80000100,badaddr=0x1003 -> exc_pc 0x800000FC,bd=1,code 0x05,badvaddr 0x1003.
//  3 hw_int_async[2]=1,IM[4]=1,IE=1,EXL=0 -> hw_int_sync after 2 clk; next valid instr code 0x00 beats mem_ri.
//  4 same with EXL=1 -> no interrupt; mem_ri still taken code 0x0A.
//  5 mem_eret,cp0_epc=0x80000200, redirect_ready low 3 clk -> exc_eret 1 pulse, flush/valid held 3 clk, pc 0x80000200.
//  6 rst asserted in REDIR -> next cycle flush=0,redirect_valid=0,no exc_valid.

Source files
------------

// File: rtl/exc_arbiter_if.sv
// Redirect/flush handshake between the exception arbiter and the fetch stage.
// The arbiter drives flush and the redirect PC; fetch answers with redirect_ready.
interface exc_arbiter_if;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exc_arbiter.sv
// Commit-point exception/interrupt arbiter: picks one winner from the MEM stage
// flags and pending interrupts, feeds cop0 capture ports, and flushes/redirects fetch.
module exc_arbiter #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_bd,
  input  logic        mem_adel_if,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_syscall,
  input  logic        mem_break,
  input  logic        mem_adel_ld,
  input  logic        mem_ades,
  input  logic        mem_eret,
  input  logic [31:0] mem_badaddr,
  input  logic [5:0]  hw_int_async,
  input  logic        cp0_is_ie,
  input  logic        cp0_is_exl,
  input  logic [7:0]  cp0_int_mask,
  input  logic [1:0]  cp0_soft_int,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  hw_int_sync,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        exc_bd,
  output logic        exc_we_badvaddr,
  output logic [31:0] exc_badvaddr,
  output logic        exc_eret,
  exc_arbiter_if.master redir
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0][5:0] sync_p0;
  logic [7:0]  int_pend;
  logic        int_req;
  logic        take;
  logic [31:0] redirect_pc_p0;

  // Interrupt synchroniser: SYNC_STAGES flops, oldest sample in the top slot
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], hw_int_async};
    end
  end

  assign hw_int_sync = sync_p0[SYNC_STAGES-1];
  assign int_pend    = {hw_int_sync, cp0_soft_int} & cp0_int_mask;
  assign int_req     = cp0_is_ie & ~cp0_is_exl & (|int_pend);

  // Reset also gates take so no capture pulse can leak to cop0 during rst
  assign take = (state == IDLE) & mem_valid & ~rst;

  always_comb begin
    exc_valid       = 1'b0;
    exc_code        = 5'h00;
    exc_pc          = 32'h0;
    exc_bd          = 1'b0;
    exc_we_badvaddr = 1'b0;
    exc_badvaddr    = 32'h0;
    exc_eret        = 1'b0;
    if (take) begin
      if (int_req) begin
        exc_valid = 1'b1;
        exc_code  = 5'h00;
      end else if (mem_adel_if) begin
        exc_valid       = 1'b1;
        exc_code        = 5'h04;
        exc_we_badvaddr = 1'b1;
        exc_badvaddr    = mem_pc;
      end else if (mem_ri) begin
        exc_valid = 1'b1;
        exc_code  = 5'h0A;
      end else if (mem_ov) begin
        exc_valid = 1'b1;
        exc_code  = 5'h0C;
      end else if (mem_syscall) begin
        exc_valid = 1'b1;
        exc_code  = 5'h08;
      end else if (mem_break) begin
        exc_valid = 1'b1;
        exc_code  = 5'h09;
      end else if (mem_adel_ld) begin
        exc_valid       = 1'b1;
        exc_code        = 5'h04;
        exc_we_badvaddr = 1'b1;
        exc_badvaddr    = mem_badaddr;
      end else if (mem_ades) begin
        exc_valid       = 1'b1;
        exc_code        = 5'h05;
        exc_we_badvaddr = 1'b1;
        exc_badvaddr    = mem_badaddr;
      end else if (mem_eret) begin
        exc_eret = 1'b1;
      end
    end
    // EPC points at the branch when the faulting instruction is in its delay slot
    if (exc_valid) begin
      exc_bd = mem_is_bd;
      exc_pc = mem_is_bd ? (mem_pc - 32'd4) : mem_pc;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (exc_valid || exc_eret) next_state = REDIR;
      REDIR:   if (redir.redirect_ready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Redirect stage: state and target PC registered at the commit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_p0 <= 32'h0;
    end else if (exc_valid) begin
      redirect_pc_p0 <= EXC_VECTOR;
    end else if (exc_eret) begin
      redirect_pc_p0 <= cp0_epc;
    end
  end

  assign redir.flush          = (state == REDIR);
  assign redir.redirect_valid = (state == REDIR);
  assign redir.redirect_pc    = redirect_pc_p0;

endmodule

// File: tb/tb_exc_arbiter.sv
// Scoreboard bench for exc_arbiter: stimulus pushes expected cop0 pulses and
// redirects into queues; a negedge monitor pops and compares what the DUT presents.
module tb_exc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_is_bd;
  logic [31:0] mem_pc, mem_badaddr;
  logic        mem_adel_if, mem_ri, mem_ov, mem_syscall, mem_break;
  logic        mem_adel_ld, mem_ades, mem_eret;
  logic [5:0]  hw_int_async;
  logic        cp0_is_ie, cp0_is_exl;
  logic [7:0]  cp0_int_mask;
  logic [1:0]  cp0_soft_int;
  logic [31:0] cp0_epc;
  logic [5:0]  hw_int_sync;
  logic        exc_valid, exc_bd, exc_we_badvaddr, exc_eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;

  exc_arbiter_if rif ();

  exc_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_is_bd(mem_is_bd),
    .mem_adel_if(mem_adel_if), .mem_ri(mem_ri), .mem_ov(mem_ov),
    .mem_syscall(mem_syscall), .mem_break(mem_break),
    .mem_adel_ld(mem_adel_ld), .mem_ades(mem_ades), .mem_eret(mem_eret),
    .mem_badaddr(mem_badaddr), .hw_int_async(hw_int_async),
    .cp0_is_ie(cp0_is_ie), .cp0_is_exl(cp0_is_exl),
    .cp0_int_mask(cp0_int_mask), .cp0_soft_int(cp0_soft_int), .cp0_epc(cp0_epc),
    .hw_int_sync(hw_int_sync), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_we_badvaddr(exc_we_badvaddr),
    .exc_badvaddr(exc_badvaddr), .exc_eret(exc_eret),
    .redir(rif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        we;
    logic [31:0] bad;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } rexp_t;

  exp_t  exp_q[$];
  rexp_t rexp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    rcnt     = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Monitor: every cop0 pulse and every completed redirect must match the queue head
  always @(negedge clk) begin
    exp_t  e;
    rexp_t r;
    if (exc_valid || exc_eret) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'h0, exc_valid, exc_eret}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("exc_valid", {31'h0, exc_valid}, {31'h0, ~e.eret});
        chk("exc_eret", {31'h0, exc_eret}, {31'h0, e.eret});
        if (!e.eret) begin
          chk("exc_code", {27'h0, exc_code}, {27'h0, e.code});
          chk("exc_pc", exc_pc, e.pc);
          chk("exc_bd", {31'h0, exc_bd}, {31'h0, e.bd});
          chk("exc_we_badvaddr", {31'h0, exc_we_badvaddr}, {31'h0, e.we});
          if (e.we) chk("exc_badvaddr", exc_badvaddr, e.bad);
        end
      end
    end
    if (rif.redirect_valid) begin
      rcnt++;
      chk("flush_with_valid", {31'h0, rif.flush}, 32'h1);
      if (rif.redirect_ready) begin
        if (rexp_q.size() == 0) begin
          chk("unexpected_redirect", rif.redirect_pc, 32'hFFFF_FFFF);
        end else begin
          r = rexp_q.pop_front();
          chk("redirect_pc", rif.redirect_pc, r.pc);
          chk("redirect_cycles", rcnt, r.cyc);
        end
        rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  end

  task automatic set_flags(input logic [7:0] fl);
    {mem_adel_if, mem_ri, mem_ov, mem_syscall, mem_break, mem_adel_ld, mem_ades, mem_eret} = fl;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rif.redirect_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("redirect_timeout", n, (n < 20) ? n : 0);
  endtask

  // flags: {adel_if, ri, ov, syscall, break, adel_ld, ades, eret}; call at posedge+1
  task automatic issue(input logic [31:0] pc, input logic bd, input logic [7:0] fl,
                       input logic [31:0] bad, input logic [31:0] epc, input int ready_low,
                       input logic hold, input exp_t e, input logic [31:0] rpc);
    rexp_t r;
    rif.redirect_ready = (ready_low == 0);
    mem_pc = pc; mem_is_bd = bd; mem_badaddr = bad; cp0_epc = epc;
    set_flags(fl);
    mem_valid = 1'b1;
    exp_q.push_back(e);
    r.pc = rpc; r.cyc = (ready_low == 0) ? 1 : ready_low;
    rexp_q.push_back(r);
    @(posedge clk); #1;
    if (!hold) begin
      mem_valid = 1'b0;
      set_flags(8'h00);
    end
    if (ready_low > 1) begin
      repeat (ready_low - 1) @(posedge clk);
      #1;
    end
    rif.redirect_ready = 1'b1;
    wait_idle();
    mem_valid = 1'b0;
    set_flags(8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mem_valid = 1'b1; mem_pc = 32'h8000_0000; mem_is_bd = 1'b0; mem_badaddr = 32'h0;
    set_flags(8'b0010_0000);
    hw_int_async = 6'h0; cp0_is_ie = 1'b0; cp0_is_exl = 1'b0;
    cp0_int_mask = 8'h00; cp0_soft_int = 2'b00; cp0_epc = 32'h0;
    rif.redirect_ready = 1'b1;

    // Reset with a live overflow on MEM: nothing may escape
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {31'h0, rif.flush}, 32'h0);
    chk("rst_redirect_valid", {31'h0, rif.redirect_valid}, 32'h0);
    chk("rst_redirect_pc", rif.redirect_pc, 32'h0);
    chk("rst_hw_int_sync", {26'h0, hw_int_sync}, 32'h0);
    chk("rst_exc_valid", {31'h0, exc_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b0; set_flags(8'h00);
    @(posedge clk); #1;

    issue(32'h8000_0010, 1'b0, 8'b0010_0000, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h0C, 32'h8000_0010, 1'b0, 1'b0, 32'h0}, VEC);
    issue(32'h8000_0100, 1'b1, 8'b0000_0010, 32'h0000_1003, 32'h0, 1, 1'b0,
          '{1'b0, 5'h05, 32'h8000_00FC, 1'b1, 1'b1, 32'h0000_1003}, VEC);
    issue(32'h8000_0020, 1'b0, 8'b1110_0000, 32'h0000_DEAD, 32'h0, 0, 1'b0,
          '{1'b0, 5'h04, 32'h8000_0020, 1'b0, 1'b1, 32'h8000_0020}, VEC);
    issue(32'h8000_0030, 1'b0, 8'b0001_1000, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h08, 32'h8000_0030, 1'b0, 1'b0, 32'h0}, VEC);
    issue(32'h8000_0034, 1'b0, 8'b0000_1100, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h09, 32'h8000_0034, 1'b0, 1'b0, 32'h0}, VEC);
    issue(32'h8000_0038, 1'b0, 8'b0000_0111, 32'h0000_2002, 32'h8000_0400, 2, 1'b0,
          '{1'b0, 5'h04, 32'h8000_0038, 1'b0, 1'b1, 32'h0000_2002}, VEC);
    issue(32'h8000_003C, 1'b0, 8'b0010_0001, 32'h0, 32'h8000_0400, 0, 1'b0,
          '{1'b0, 5'h0C, 32'h8000_003C, 1'b0, 1'b0, 32'h0}, VEC);
    issue(32'h0000_0000, 1'b1, 8'b0100_0000, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h0A, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0}, VEC);

    // Hardware interrupt line 2 maps to IM[4]; two-flop synchroniser latency
    hw_int_async = 6'b00_0100; cp0_is_ie = 1'b1; cp0_int_mask = 8'h10;
    @(negedge clk);
    chk("sync_lat0", {26'h0, hw_int_sync}, 32'h0);
    @(negedge clk);
    chk("sync_lat1", {26'h0, hw_int_sync}, 32'h0);
    @(negedge clk);
    chk("sync_lat2", {26'h0, hw_int_sync}, 32'h4);
    @(posedge clk); #1;
    issue(32'h8000_0040, 1'b0, 8'b0100_0000, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h00, 32'h8000_0040, 1'b0, 1'b0, 32'h0}, VEC);
    cp0_is_exl = 1'b1;
    issue(32'h8000_0044, 1'b0, 8'b0100_0000, 32'h0, 32'h0, 0, 1'b0,
          '{1'b0, 5'h0A, 32'h8000_0044, 1'b0, 1'b0, 32'h0}, VEC);
    hw_int_async = 6'h0; cp0_is_exl = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Software interrupt IP[1] beats a pending ERET
    cp0_soft_int = 2'b10; cp0_int_mask = 8'h02;
    issue(32'h8000_0048, 1'b0, 8'b0000_0001, 32'h0, 32'h8000_0300, 0, 1'b0,
          '{1'b0, 5'h00, 32'h8000_0048, 1'b0, 1'b0, 32'h0}, VEC);
    cp0_soft_int = 2'b00; cp0_int_mask = 8'h00; cp0_is_ie = 1'b0;

    // ERET with slow fetch: MEM held valid through REDIR must not re-fire
    issue(32'h8000_0050, 1'b0, 8'b0000_0001, 32'h0, 32'h8000_0200, 3, 1'b1,
          '{1'b1, 5'h00, 32'h0, 1'b0, 1'b0, 32'h0}, 32'h8000_0200);

    // Reset while parked in REDIR
    rif.redirect_ready = 1'b0;
    mem_pc = 32'h8000_0060; mem_is_bd = 1'b0; set_flags(8'b0000_1000); mem_valid = 1'b1;
    exp_q.push_back('{1'b0, 5'h09, 32'h8000_0060, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_redir_flush", {31'h0, rif.flush}, 32'h0);
    chk("rst_redir_valid", {31'h0, rif.redirect_valid}, 32'h0);
    chk("rst_redir_pc", rif.redirect_pc, 32'h0);
    chk("rst_redir_exc_valid", {31'h0, exc_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b0; set_flags(8'h00); rif.redirect_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("exc_queue_empty", exp_q.size(), 32'h0);
    chk("redirect_queue_empty", rexp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
